// File: rtl/ula_pkg.sv
// Shared opcode constants, FSM state encoding and opcode legality helper for the ULA arbiter.
// Purely declarative: no logic, no latency.
// No flow control here; consumers decide how opcodes are handled.
package ula_pkg;

  localparam logic [3:0] ULA_OP_AND = 4'b0000;
  localparam logic [3:0] ULA_OP_OR  = 4'b0001;
  localparam logic [3:0] ULA_OP_ADD = 4'b0010;
  localparam logic [3:0] ULA_OP_SUB = 4'b0110;
  localparam logic [3:0] ULA_OP_SLT = 4'b0111;
  localparam logic [3:0] ULA_OP_NOP = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // True for the five opcodes the ULA actually implements.
  function automatic logic ula_op_legal(input logic [3:0] op);
    return (op == ULA_OP_AND) || (op == ULA_OP_OR) || (op == ULA_OP_ADD) ||
           (op == ULA_OP_SUB) || (op == ULA_OP_SLT);
  endfunction

endpackage

// File: rtl/ula_arbiter_if.sv
// Requester-side bundle of the ULA arbiter: per-requester command and response handshakes.
// Wires only, no latency.
// master = requesters (drive commands, accept results); slave = arbiter.
interface ula_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [4*NUM_REQ-1:0]      req_op;
  logic [DATA_W*NUM_REQ-1:0] req_a;
  logic [DATA_W*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ-1:0]        resp_ready;
  logic [DATA_W-1:0]         resp_data;
  logic                      resp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request scanning from ptr upward, wrapping at NUM_REQ.
// Purely combinational, zero latency.
// No backpressure; caller qualifies the grant with its own state.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [PTR_W-1:0] cand;

  // Scan ptr, ptr+1, ... mod NUM_REQ and keep the first requester found.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = PTR_W'((int'(ptr) + off) % NUM_REQ);
      if (!grant_any && req[cand]) begin
        grant_any       = 1'b1;
        grant[cand]     = 1'b1;
        grant_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/ula_arbiter.sv
// Shares one registered ULA among NUM_REQ requesters, round-robin, one operation in flight.
// Accept in IDLE, result presented three cycles after the accept cycle; 4 cycles per op unstalled.
// Response held until the owner's resp_ready; no new command is granted while a result is held.
// Optional build macro ULA_OPCHECK_EN: illegal opcodes are answered directly with resp_err=1.
module ula_arbiter
  import ula_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  ula_arbiter_if.slave      bus,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;
  logic [3:0]          alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [PTR_W-1:0]    gnt_idx;
  logic                gnt_any;
  logic [3:0]          op_sel;
  logic [DATA_W-1:0]   a_sel;
  logic [DATA_W-1:0]   b_sel;
  logic                illegal;
  logic                resp_hs;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_q),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  // Select the winner's command slice; grant is one-hot so at most one iteration hits.
  always_comb begin
    op_sel = ULA_OP_NOP;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        op_sel = bus.req_op[4*i +: 4];
        a_sel  = bus.req_a[DATA_W*i +: DATA_W];
        b_sel  = bus.req_b[DATA_W*i +: DATA_W];
      end
    end
`ifdef ULA_OPCHECK_EN
    illegal = !ula_op_legal(op_sel);
`else
    illegal = 1'b0;
`endif
  end

  // Grant is only offered in IDLE, which also keeps it off while a result is held.
  always_comb begin
    bus.req_ready = (state_q == ST_IDLE) ? gnt : '0;
  end

  assign resp_hs = |(resp_valid_q & bus.resp_ready);

  // Next-state and next-output computation for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          owner_d  = gnt_idx;
          rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
          if (illegal) begin
            // Answer directly without touching the ULA.
            state_d      = ST_RESP;
            resp_valid_d = gnt;
            resp_data_d  = '0;
            resp_err_d   = 1'b1;
          end else begin
            state_d  = ST_ISSUE;
            alu_op_d = op_sel;
            alu_a_d  = a_sel;
            alu_b_d  = b_sel;
          end
        end
      end
      ST_ISSUE: begin
        // ULA registers alu_* on this edge.
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_d               = ST_RESP;
        resp_data_d           = alu_result;
        resp_err_d            = 1'b0;
        resp_valid_d          = '0;
        resp_valid_d[owner_q] = 1'b1;
      end
      ST_RESP: begin
        if (resp_hs) begin
          state_d      = ST_IDLE;
          resp_valid_d = '0;
          resp_err_d   = 1'b0;
          alu_op_d     = ULA_OP_NOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      alu_op_q     <= ULA_OP_NOP;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign alu_op         = alu_op_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;

endmodule
